// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback select stage.
// Load-extension constants are used only when WB_LOAD_EXT_EN is defined.
package wb_pkg;

  localparam int XLEN_DEF    = 64;
  localparam int RADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    WB_ALU  = 3'd0,
    WB_PC4  = 3'd1,
    WB_SEXT = 3'd2,
    WB_BR   = 3'd3,
    WB_DMEM = 3'd4
  } wb_sel_e;

  typedef struct packed {
    logic [RADDR_W_DEF-1:0] rd_addr;
    logic                   wen;
    logic [XLEN_DEF-1:0]    data;
  } wb_entry_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_load_ext.sv
// Load lane extract and sign/zero extension for raw dmem dwords.
// Compiled only when WB_LOAD_EXT_EN is defined.
`ifdef WB_LOAD_EXT_EN
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      funct3,
  input  logic [2:0]      off,
  output logic [XLEN-1:0] data
);

  logic [2:0]      off_m;
  logic [XLEN-1:0] sh;

  // Misaligned offsets drop the low bits below the access size.
  always_comb begin
    off_m = off;
    unique case (funct3)
      F3_LH, F3_LHU: off_m = {off[2:1], 1'b0};
      F3_LW, F3_LWU: off_m = {off[2], 2'b00};
      F3_LD:         off_m = 3'b000;
      default:       off_m = off;
    endcase
  end

  assign sh = raw >> {off_m, 3'b000};

  always_comb begin
    data = raw;
    unique case (funct3)
      F3_LB:   data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_LH:   data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_LW:   data = {{(XLEN-32){sh[31]}}, sh[31:0]};
      F3_LD:   data = sh;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, sh[15:0]};
      F3_LWU:  data = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: data = raw;
    endcase
  end

endmodule
`endif

// File: rtl/wb_select_stage.sv
// Writeback select stage: source mux into a 2-entry skid buffer with forwarding lookup.
// Define WB_LOAD_EXT_EN to route source LOAD_IDX through wb_load_ext.
//
// state    | meaning
// ST_EMPTY | no entry buffered, out_valid low
// ST_ONE   | main holds the head entry
// ST_TWO   | main is head, skid holds the younger entry; input stalled
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NSRC     = 5,
  parameter int SEL_W    = $clog2(NSRC),
  parameter int RADDR_W  = 5,
  parameter int LOAD_IDX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic [NSRC*XLEN-1:0] in_srcs,
  input  logic [RADDR_W-1:0]   in_rd_addr,
  input  logic                 in_wen,
  input  logic [2:0]           in_ld_funct3,
  input  logic [2:0]           in_ld_off,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RADDR_W-1:0]   out_rd_addr,
  output logic                 out_wen,
  output logic [XLEN-1:0]      out_data,
  input  logic [RADDR_W-1:0]   fwd_raddr,
  output logic                 fwd_hit,
  output logic [XLEN-1:0]      fwd_data
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  state_e             state;
  logic [XLEN-1:0]    src_arr [NSRC];
  logic [XLEN-1:0]    sel_data;
  logic [XLEN-1:0]    new_data;
  logic               new_wen;
  logic [RADDR_W-1:0] skid_rd_addr;
  logic               skid_wen;
  logic [XLEN-1:0]    skid_data;
  logic               in_fire;
  logic               out_fire;
  logic               hit_main;
  logic               hit_skid;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    if (g == LOAD_IDX) begin : g_ld
`ifdef WB_LOAD_EXT_EN
      wb_load_ext #(.XLEN(XLEN)) u_load_ext (
        .raw    (in_srcs[g*XLEN +: XLEN]),
        .funct3 (in_ld_funct3),
        .off    (in_ld_off),
        .data   (src_arr[g])
      );
`else
      assign src_arr[g] = in_srcs[g*XLEN +: XLEN];
`endif
    end else begin : g_raw
      assign src_arr[g] = in_srcs[g*XLEN +: XLEN];
    end
  end

`ifndef WB_LOAD_EXT_EN
  logic unused_ld;
  assign unused_ld = ^{in_ld_funct3, in_ld_off};
`endif

  // Out-of-range select codes fall back to source 0.
  always_comb begin
    sel_data = src_arr[0];
    for (int i = 1; i < NSRC; i++) begin
      if (in_sel == SEL_W'(i)) sel_data = src_arr[i];
    end
  end

  assign new_wen  = in_wen && (in_rd_addr != '0);
  assign new_data = (in_rd_addr != '0) ? sel_data : '0;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_rd_addr  <= '0;
      out_wen      <= 1'b0;
      out_data     <= '0;
      skid_rd_addr <= '0;
      skid_wen     <= 1'b0;
      skid_data    <= '0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            out_rd_addr <= in_rd_addr;
            out_wen     <= new_wen;
            out_data    <= new_data;
            out_valid   <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            out_rd_addr <= in_rd_addr;
            out_wen     <= new_wen;
            out_data    <= new_data;
          end else if (in_fire) begin
            skid_rd_addr <= in_rd_addr;
            skid_wen     <= new_wen;
            skid_data    <= new_data;
            in_ready     <= 1'b0;
            state        <= ST_TWO;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            out_rd_addr <= skid_rd_addr;
            out_wen     <= skid_wen;
            out_data    <= skid_data;
            in_ready    <= 1'b1;
            state       <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Skid is the younger entry, so its match takes priority.
  assign hit_main = out_valid && out_wen && (out_rd_addr == fwd_raddr);
  assign hit_skid = (state == ST_TWO) && skid_wen && (skid_rd_addr == fwd_raddr);
  assign fwd_hit  = (fwd_raddr != '0) && (hit_main || hit_skid);
  assign fwd_data = (fwd_raddr == '0) ? '0 :
                    hit_skid ? skid_data :
                    hit_main ? out_data  : '0;

endmodule
